// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode/state encodings and defaults for alu_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int OP_W_DEFAULT = 5;
    localparam int ALU_NUM_OPS  = 24;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SRL    = 5'd3,
        OP_SRA    = 5'd4,
        OP_SLT    = 5'd5,
        OP_SLTU   = 5'd6,
        OP_XOR    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_BEQ    = 5'd10,
        OP_BNE    = 5'd11,
        OP_BLT    = 5'd12,
        OP_BGE    = 5'd13,
        OP_BLTU   = 5'd14,
        OP_BGEU   = 5'd15,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter
//  Description : Radix-2 unsigned shift-add multiplier / restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    localparam int                 c_cnt_w = $clog2(XLEN) + 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(XLEN - 1);

    logic               r_busy;
    logic               r_is_div;
    logic [c_cnt_w-1:0] r_cnt;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    r_m;

    logic [XLEN:0]      w_sum;
    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_diff;
    logic [XLEN-1:0]    w_hi_nxt;
    logic [XLEN-1:0]    w_lo_nxt;

    // Mul: {hi,lo} shifts right with hi accumulating. Div: {rem,quot} shifts left.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
        w_shift  = {r_hi, r_lo[XLEN-1]};
        w_diff   = w_shift - {1'b0, r_m};
        w_hi_nxt = w_sum[XLEN:1];
        w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        if (r_is_div) begin
            if (!w_diff[XLEN]) begin
                w_hi_nxt = w_diff[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift[XLEN-1:0];
                w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= i_is_div;
            r_hi     <= '0;
            r_lo     <= i_is_div ? i_op_a : i_op_b;
            r_m      <= i_is_div ? i_op_b : i_op_a;
        end else if (r_busy) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_cnt == c_last) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Final iteration result is presented combinationally so the caller can
    // register it on the same edge the last step would have been stored.
    assign o_done = r_busy && (r_cnt == c_last);
    assign o_hi   = w_hi_nxt;
    assign o_lo   = w_lo_nxt;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Sequential RV32IM-style ALU with valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int OP_W = OP_W_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [OP_W-1:0] op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            branch_feedback_o
);

    localparam int c_sh_w  = $clog2(XLEN);
    localparam int c_op_xw = (OP_W > 5) ? OP_W : 5;

    alu_state_e        r_state;
    alu_state_e        w_state_nxt;
    alu_op_e           r_op;
    logic              r_neg;

    logic [c_op_xw-1:0] w_op_x;
    alu_op_e            w_op;
    logic               w_op_known;
    logic               w_is_md;
    logic               w_is_div;
    logic               w_accept;
    logic               w_start;
    logic               w_signed_a;
    logic               w_signed_b;
    logic               w_neg_a;
    logic               w_neg_b;
    logic               w_neg_res;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_bypass;
    logic [c_sh_w-1:0]  w_shamt;
    logic [XLEN-1:0]    w_res;
    logic               w_br;
    logic               w_md_done;
    logic [XLEN-1:0]    w_md_hi;
    logic [XLEN-1:0]    w_md_lo;
    logic [2*XLEN-1:0]  w_prod_c;
    logic [XLEN-1:0]    w_fin;

    assign w_op_x     = c_op_xw'(op_i);
    assign w_op_known = (w_op_x < c_op_xw'(ALU_NUM_OPS));
    assign w_op       = alu_op_e'(w_op_x[4:0]);
    assign w_is_md    = w_op_known && w_op_x[4];
    assign w_is_div   = w_is_md && w_op_x[2];

    assign ready_o  = (r_state == ST_IDLE);
    assign valid_o  = (r_state == ST_DONE);
    assign w_accept = valid_i && ready_o && !kill_i;

    // Signed mul/div run on magnitudes; the sign is restored on completion.
    assign w_signed_a = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                        (w_op == OP_DIV)  || (w_op == OP_REM);
    assign w_signed_b = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_neg_a    = w_signed_a && src1_i[XLEN-1];
    assign w_neg_b    = w_signed_b && src2_i[XLEN-1];
    assign w_mag_a    = w_neg_a ? -src1_i : src1_i;
    assign w_mag_b    = w_neg_b ? -src2_i : src2_i;
    assign w_neg_res  = (w_op == OP_REM) ? w_neg_a : (w_neg_a ^ w_neg_b);

    assign w_div_zero = w_is_div && (src2_i == '0);
    assign w_ovf      = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                        (src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&src2_i);
    assign w_bypass   = w_div_zero || w_ovf;
    assign w_start    = w_accept && w_is_md && !w_bypass;
    assign w_shamt    = src2_i[c_sh_w-1:0];

    // Single-cycle results, including the div-by-zero / overflow shortcuts.
    always_comb begin
        w_res = '0;
        w_br  = 1'b0;
        if (w_op_known) begin
            case (w_op)
                OP_ADD:  w_res = src1_i + src2_i;
                OP_SUB:  w_res = src1_i - src2_i;
                OP_SLL:  w_res = src1_i << w_shamt;
                OP_SRL:  w_res = src1_i >> w_shamt;
                OP_SRA:  w_res = $unsigned($signed(src1_i) >>> w_shamt);
                OP_SLT:  w_res = {{(XLEN-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
                OP_SLTU: w_res = {{(XLEN-1){1'b0}}, src1_i < src2_i};
                OP_XOR:  w_res = src1_i ^ src2_i;
                OP_OR:   w_res = src1_i | src2_i;
                OP_AND:  w_res = src1_i & src2_i;
                OP_BEQ:  w_br  = (src1_i == src2_i);
                OP_BNE:  w_br  = (src1_i != src2_i);
                OP_BLT:  w_br  = ($signed(src1_i) <  $signed(src2_i));
                OP_BGE:  w_br  = ($signed(src1_i) >= $signed(src2_i));
                OP_BLTU: w_br  = (src1_i <  src2_i);
                OP_BGEU: w_br  = (src1_i >= src2_i);
                OP_DIV, OP_DIVU: w_res = w_div_zero ? '1 : src1_i;
                OP_REM, OP_REMU: w_res = w_div_zero ? src1_i : '0;
                default: w_res = '0;
            endcase
        end
    end

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .i_start  (w_start),
        .i_abort  (kill_i),
        .i_is_div (w_is_div),
        .i_op_a   (w_mag_a),
        .i_op_b   (w_mag_b),
        .o_done   (w_md_done),
        .o_hi     (w_md_hi),
        .o_lo     (w_md_lo)
    );

    assign w_prod_c = r_neg ? -{w_md_hi, w_md_lo} : {w_md_hi, w_md_lo};

    always_comb begin
        w_fin = '0;
        case (r_op)
            OP_MUL:                       w_fin = w_prod_c[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fin = w_prod_c[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_fin = r_neg ? -w_md_lo : w_md_lo;
            OP_REM, OP_REMU:              w_fin = r_neg ? -w_md_hi : w_md_hi;
            default:                      w_fin = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_start ? ST_CALC : ST_DONE;
            ST_CALC: begin
                if (kill_i)         w_state_nxt = ST_IDLE;
                else if (w_md_done) w_state_nxt = ST_DONE;
            end
            // Kill racing a handshake still retires the result exactly once.
            ST_DONE: if (kill_i || ready_i) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state           <= ST_IDLE;
            r_op              <= OP_ADD;
            r_neg             <= 1'b0;
            result_o          <= '0;
            branch_feedback_o <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_op;
                        r_neg <= w_neg_res;
                        if (!w_start) begin
                            result_o          <= w_res;
                            branch_feedback_o <= w_br;
                        end
                    end
                end
                ST_CALC: begin
                    if (kill_i) begin
                        result_o          <= '0;
                        branch_feedback_o <= 1'b0;
                    end else if (w_md_done) begin
                        result_o          <= w_fin;
                        branch_feedback_o <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (kill_i || ready_i) begin
                        result_o          <= '0;
                        branch_feedback_o <= 1'b0;
                    end
                end
                default: begin
                    result_o          <= '0;
                    branch_feedback_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
